// File: rtl/int_div_unit_if.sv
// Launch/result signal bundle between the EXE-stage control logic and the integer divider.
// The master drives the launch side; the slave returns the result side.
`timescale 1ns/1ps
interface int_div_unit_if #(parameter int XLEN = 32) ();
  // A launch is one cycle of start=1 while busy=0 and flush=0; the result is valid for exactly
  // the cycles where p_last=1, and hold=1 stretches that window until hold drops or flush arrives.
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            flush;
  logic            hold;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            p_last;
  logic            busy;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in, flush, hold,
    input  result, rd_out, p_last, busy
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in, flush, hold,
    output result, rd_out, p_last, busy
  );
endinterface

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: 32 CALC steps plus a DONE cycle,
// with divide-by-zero and signed overflow resolved directly at launch.
`timescale 1ns/1ps
module int_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    int_div_unit_if.slave        dif,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op_q;
    logic            neg_quo;
    logic            neg_rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            p_last_q;

    logic            is_signed;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // op[0]=0 selects the signed variants (DIV, REM); op[1]=1 selects the remainder.
    always_comb begin
        is_signed = ~dif.op[0];
        a_abs     = (is_signed && dif.rs1_data[XLEN-1]) ? -dif.rs1_data : dif.rs1_data;
        b_abs     = (is_signed && dif.rs2_data[XLEN-1]) ? -dif.rs2_data : dif.rs2_data;
    end

    // One restoring step on {rem,quo}; the extra top bit of trial is the borrow.
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (!trial[XLEN]) begin
            rem_nx = trial[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b0};
        end
        quo_fix = neg_quo ? -quo_nx : quo_nx;
        rem_fix = neg_rem ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
            rd_q     <= '0;
            p_last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p_last_q <= 1'b0;
                    if (dif.start && !dif.flush) begin
                        op_q    <= dif.op;
                        rd_q    <= dif.rd_in;
                        neg_quo <= is_signed && (dif.rs1_data[XLEN-1] ^ dif.rs2_data[XLEN-1]);
                        neg_rem <= is_signed && dif.rs1_data[XLEN-1];
                        divisor <= b_abs;
                        quo     <= a_abs;
                        rem     <= '0;
                        cnt     <= '0;
                        if (dif.rs2_data == '0) begin
                            state    <= DONE;
                            p_last_q <= 1'b1;
                            result_q <= dif.op[1] ? dif.rs1_data : '1;
                        end else if (is_signed && dif.rs1_data == INT_MIN && dif.rs2_data == '1) begin
                            state    <= DONE;
                            p_last_q <= 1'b1;
                            result_q <= dif.op[1] ? '0 : INT_MIN;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (dif.flush) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN-1)) begin
                            state    <= DONE;
                            p_last_q <= 1'b1;
                            result_q <= op_q[1] ? rem_fix : quo_fix;
                        end
                    end
                end
                DONE: begin
                    // flush outranks hold so a killed result never lingers.
                    if (dif.flush || !dif.hold) begin
                        state    <= IDLE;
                        p_last_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    p_last_q <= 1'b0;
                end
            endcase
        end
    end

    assign dif.result = result_q;
    assign dif.rd_out = rd_q;
    assign dif.p_last = p_last_q;
    assign dif.busy   = (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_int_div_unit.sv
// Directed bench for int_div_unit: latency, results, special cases, hold, flush, reset and
// start-while-busy behaviour, each scenario in its own task.
`timescale 1ns/1ps
module tb_int_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic reset_n;
  logic [1:0] dbg_state;
  int checks;
  int errors;

  int_div_unit_if #(.XLEN(32)) dif ();

  int_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dif       (dif),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: launch and wait for p_last; lat counts edges with the start edge as 1, -1 on timeout
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
    dif.op = o; dif.rs1_data = a; dif.rs2_data = b; dif.rd_in = rd;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (dif.p_last) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    checks++;
    if (dif.result !== 32'h0 || dif.rd_out !== 5'd0 || dif.p_last !== 1'b0 || dif.busy !== 1'b0
        || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: result=%h rd=%0d p_last=%b busy=%b st=%0d required 0/0/0/0/0",
               dif.result, dif.rd_out, dif.p_last, dif.busy, dbg_state);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d required 33", lat); end
    checks++;
    if (dif.result !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h required %h", dif.result, 32'd14); end
    checks++;
    if (dif.rd_out !== 5'd5) begin errors++; $display("FAIL divu_rd: got %0d required 5", dif.rd_out); end
    tick();
    checks++;
    if (dif.p_last !== 1'b0 || dif.busy !== 1'b0) begin
      errors++; $display("FAIL done_to_idle: p_last=%b busy=%b required 0/0", dif.p_last, dif.busy);
    end
    run_op(OP_REMU, 32'd100, 32'd7, 5'd6, lat);
    checks++;
    if (dif.result !== 32'd2 || lat !== 33) begin
      errors++; $display("FAIL remu_100_7: got %h lat %0d required 2 lat 33", dif.result, lat);
    end
    tick();
  endtask

  task automatic test_signed();
    int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, lat);
    checks++;
    if (dif.result !== 32'hFFFF_FFFD || lat !== 33) begin
      errors++; $display("FAIL div_m7_2: got %h lat %0d required fffffffd lat 33", dif.result, lat);
    end
    tick();
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, lat);
    checks++;
    if (dif.result !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rem_m7_2: got %h required ffffffff", dif.result);
    end
    tick();
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd3, lat);
    checks++;
    if (dif.result !== 32'd1) begin
      errors++; $display("FAIL rem_7_m2: got %h required 00000001", dif.result);
    end
    tick();
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd4, lat);
    checks++;
    if (dif.result !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_7_m2: got %h required fffffffd", dif.result);
    end
    tick();
  endtask

  task automatic test_special();
    int lat;
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd7, lat);
    checks++;
    if (dif.result !== 32'hFFFF_FFFF || lat !== 1) begin
      errors++; $display("FAIL divu_by_zero: got %h lat %0d required ffffffff lat 1", dif.result, lat);
    end
    tick();
    run_op(OP_REM, 32'd5, 32'd0, 5'd8, lat);
    checks++;
    if (dif.result !== 32'd5 || lat !== 1) begin
      errors++; $display("FAIL rem_by_zero: got %h lat %0d required 5 lat 1", dif.result, lat);
    end
    tick();
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat);
    checks++;
    if (dif.result !== 32'h8000_0000 || lat !== 1 || dif.rd_out !== 5'd9) begin
      errors++; $display("FAIL div_overflow: got %h lat %0d rd %0d required 80000000 lat 1 rd 9",
                         dif.result, lat, dif.rd_out);
    end
    tick();
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat);
    checks++;
    if (dif.result !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL rem_overflow: got %h lat %0d required 0 lat 1", dif.result, lat);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    dif.op = OP_DIVU; dif.rs1_data = 32'd1000; dif.rs2_data = 32'd10; dif.rd_in = 5'd3;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      checks++;
      if (dif.busy !== 1'b1) begin errors++; $display("FAIL busy_cycle_%0d: got %b required 1", k, dif.busy); end
      if (dif.p_last) begin
        lat = k;
        break;
      end
      if (k == 10) begin
        dif.op = OP_REMU; dif.rs1_data = 32'd77; dif.rs2_data = 32'd5; dif.rd_in = 5'd9;
        dif.start = 1'b1;
      end else begin
        dif.start = 1'b0;
      end
      tick();
    end
    dif.start = 1'b0;
    checks++;
    if (lat !== 33 || dif.result !== 32'd100 || dif.rd_out !== 5'd3) begin
      errors++; $display("FAIL start_while_busy: lat %0d result %h rd %0d required 33 00000064 3",
                         lat, dif.result, dif.rd_out);
    end
    tick();
    checks++;
    if (dif.busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b required 0", dif.busy); end
  endtask

  task automatic test_flush();
    int seen;
    dif.op = OP_DIVU; dif.rs1_data = 32'd100; dif.rs2_data = 32'd7; dif.rd_in = 5'd4;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.p_last !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL flush_calc: busy=%b p_last=%b st=%0d required 0/0/0", dif.busy, dif.p_last, dbg_state);
    end
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (dif.p_last) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_plast: got %0d required 0", seen); end
    // flush together with start in IDLE must not launch
    dif.op = OP_DIVU; dif.rs1_data = 32'd5; dif.rs2_data = 32'd0;
    dif.start = 1'b1; dif.flush = 1'b1;
    tick();
    dif.start = 1'b0; dif.flush = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.p_last !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle: busy=%b p_last=%b required 0/0", dif.busy, dif.p_last);
    end
    // flush in DONE beats hold
    dif.hold = 1'b1;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    dif.hold = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.p_last !== 1'b0) begin
      errors++; $display("FAIL flush_beats_hold: busy=%b p_last=%b required 0/0", dif.busy, dif.p_last);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    dif.op = OP_DIVU; dif.rs1_data = 32'd100; dif.rs2_data = 32'd7; dif.rd_in = 5'd12;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (dif.result !== 32'h0 || dif.rd_out !== 5'd0 || dif.p_last !== 1'b0 || dif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_calc: result=%h rd=%0d p_last=%b busy=%b required 0/0/0/0",
                         dif.result, dif.rd_out, dif.p_last, dif.busy);
    end
    dif.hold = 1'b1;
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd13, lat);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    dif.hold = 1'b0;
    checks++;
    if (dif.result !== 32'h0 || dif.rd_out !== 5'd0 || dif.p_last !== 1'b0 || dif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_done: result=%h rd=%0d p_last=%b busy=%b required 0/0/0/0",
                         dif.result, dif.rd_out, dif.p_last, dif.busy);
    end
  endtask

  task automatic test_hold();
    int lat;
    dif.hold = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd20, lat);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dif.p_last !== 1'b1 || dif.result !== 32'd14 || dif.rd_out !== 5'd20) begin
        errors++; $display("FAIL hold_stable_%0d: p_last=%b result=%h rd=%0d required 1 0000000e 20",
                           k, dif.p_last, dif.result, dif.rd_out);
      end
      if (k < 3) tick();
    end
    dif.hold = 1'b0;
    tick();
    checks++;
    if (dif.p_last !== 1'b0 || dif.busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: p_last=%b busy=%b required 0/0", dif.p_last, dif.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(OP_DIVU, 32'd50, 32'd5, 5'd1, lat);
    // start raised while DONE: ignored there, accepted on the edge after IDLE is reached
    dif.op = OP_REMU; dif.rs1_data = 32'd50; dif.rs2_data = 32'd7; dif.rd_in = 5'd2;
    dif.start = 1'b1;
    tick();
    checks++;
    if (dif.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b required 0", dif.busy); end
    tick();
    dif.start = 1'b0;
    checks++;
    if (dif.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b required 1", dif.busy); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (dif.p_last) begin lat = k; break; end
      tick();
    end
    checks++;
    if (lat !== 33 || dif.result !== 32'd1 || dif.rd_out !== 5'd2) begin
      errors++; $display("FAIL b2b_second: lat %0d result %h rd %0d required 33 00000001 2",
                         lat, dif.result, dif.rd_out);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    dif.start = 1'b0; dif.op = 2'b00; dif.rs1_data = '0; dif.rs2_data = '0;
    dif.rd_in = '0; dif.flush = 1'b0; dif.hold = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
